// File: rtl/flash_pkg.sv
// flash_pkg: FSM states, TileLink opcodes and beat-count helper for the burst splitter (DENY exists only with FLASH_BURST_ALIGN_CHECK_EN)
package flash_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
`ifdef FLASH_BURST_ALIGN_CHECK_EN
    , DENY
`endif
  } state_e;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] GET = 3'd4;
  function automatic logic [15:0] beat_count(logic [3:0] size, logic [3:0] max_size);
    logic [3:0] s;
    s = (size > max_size) ? max_size : size;
    return (s < 4'd2) ? 16'd1 : 16'd1 << (s - 4'd2);
  endfunction
endpackage

// File: rtl/flash_burst_splitter_if.sv
// flash_burst_splitter_if: TL-UL Get channel A plus channel D bundle with master/slave views
interface flash_burst_splitter_if #(parameter int TL_RS = 4);
  logic [3:0] a_size;
  logic [TL_RS-1:0] a_source;
  logic [23:0] a_address;
  logic a_valid;
  logic a_ready;
  logic [2:0] d_opcode;
  logic [1:0] d_param;
  logic [3:0] d_size;
  logic [TL_RS-1:0] d_source;
  logic d_denied;
  logic [31:0] d_data;
  logic d_corrupt;
  logic d_valid;
  logic d_ready;
  modport master (output a_size, a_source, a_address, a_valid, d_ready,
                  input a_ready, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid);
  modport slave (input a_size, a_source, a_address, a_valid, d_ready,
                 output a_ready, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid);
endinterface

// File: rtl/flash_burst_splitter.sv
// flash_burst_splitter: splits one TL-UL Get burst into serial 4-byte flash Gets; FLASH_BURST_ALIGN_CHECK_EN denies misaligned bursts
module flash_burst_splitter
  import flash_pkg::*;
#(
  parameter int TL_RS = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic             fctrl_clock_i,
  input  logic             fctrl_reset_i,
  input  logic [3:0]       burst_a_size,
  input  logic [TL_RS-1:0] burst_a_source,
  input  logic [23:0]      burst_a_address,
  input  logic             burst_a_valid,
  output logic             burst_a_ready,
  output logic [2:0]       burst_d_opcode,
  output logic [1:0]       burst_d_param,
  output logic [3:0]       burst_d_size,
  output logic [TL_RS-1:0] burst_d_source,
  output logic             burst_d_denied,
  output logic [31:0]      burst_d_data,
  output logic             burst_d_corrupt,
  output logic             burst_d_valid,
  input  logic             burst_d_ready,
  output logic [3:0]       fctrl_a_size,
  output logic [TL_RS-1:0] fctrl_a_source,
  output logic [23:0]      fctrl_a_address,
  output logic             fctrl_a_valid,
  input  logic             fctrl_a_ready,
  input  logic [2:0]       fctrl_d_opcode,
  input  logic [1:0]       fctrl_d_param,
  input  logic [3:0]       fctrl_d_size,
  input  logic [TL_RS-1:0] fctrl_d_source,
  input  logic             fctrl_d_denied,
  input  logic [31:0]      fctrl_d_data,
  input  logic             fctrl_d_corrupt,
  input  logic             fctrl_d_valid,
  output logic             fctrl_d_ready
);
  localparam int KW = MAX_SIZE - 1;
  state_e state_q, state_d;
  logic [TL_RS-1:0] src_q, src_d;
  logic [3:0] size_q, size_d;
  logic [23:0] addr_q, addr_d, mask;
  logic [KW-1:0] k_q, k_d, last;
  logic unused_d_fields;
  assign unused_d_fields = ^{fctrl_d_size, fctrl_d_source};
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    size_d = size_q;
    addr_d = addr_q;
    k_d = k_q;
    mask = (burst_a_size >= 4'd2) ? ~(24'hFFFFFF << burst_a_size) : 24'h0;
    last = KW'(beat_count(size_q, 4'(MAX_SIZE)) - 16'd1);
    burst_a_ready = 1'b0;
    fctrl_a_valid = 1'b0;
    fctrl_a_size = (size_q < 4'd2) ? size_q : 4'd2;
    fctrl_a_source = src_q;
    fctrl_a_address = addr_q + 24'({k_q, 2'b00});
    fctrl_d_ready = 1'b0;
    burst_d_valid = 1'b0;
    burst_d_opcode = fctrl_d_opcode;
    burst_d_param = fctrl_d_param;
    burst_d_size = size_q;
    burst_d_source = src_q;
    burst_d_denied = fctrl_d_denied;
    burst_d_data = fctrl_d_data;
    burst_d_corrupt = fctrl_d_corrupt;
    case (state_q)
      IDLE: begin
        burst_a_ready = 1'b1;
        fctrl_d_ready = 1'b1;
        if (burst_a_valid) begin
          src_d = burst_a_source;
          size_d = burst_a_size;
          addr_d = burst_a_address & ~mask;
          k_d = '0;
`ifdef FLASH_BURST_ALIGN_CHECK_EN
          state_d = |(burst_a_address & mask) ? DENY : ISSUE;
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        fctrl_a_valid = 1'b1;
        state_d = fctrl_a_ready ? WAIT : ISSUE;
      end
      WAIT: begin
        burst_d_valid = fctrl_d_valid;
        fctrl_d_ready = burst_d_ready;
        if (fctrl_d_valid && burst_d_ready) begin
          k_d = k_q + KW'(1);
          state_d = (k_q == last) ? IDLE : ISSUE;
        end
      end
`ifdef FLASH_BURST_ALIGN_CHECK_EN
      DENY: begin
        burst_d_valid = 1'b1;
        burst_d_opcode = ACCESS_ACK_DATA;
        burst_d_param = 2'd0;
        burst_d_denied = 1'b1;
        burst_d_data = 32'd0;
        burst_d_corrupt = 1'b1;
        if (burst_d_ready) begin
          k_d = k_q + KW'(1);
          state_d = (k_q == last) ? IDLE : DENY;
        end
      end
`endif
      default: ;
    endcase
    // handshakes stay closed during reset whatever the pre-reset state was
    if (fctrl_reset_i) begin
      burst_a_ready = 1'b0;
      fctrl_a_valid = 1'b0;
      burst_d_valid = 1'b0;
      fctrl_d_ready = 1'b0;
    end
  end
  always_ff @(posedge fctrl_clock_i) begin
    if (fctrl_reset_i) begin
      state_q <= IDLE;
      src_q <= '0;
      size_q <= '0;
      addr_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      size_q <= size_d;
      addr_q <= addr_d;
      k_q <= k_d;
    end
  end
endmodule

// File: tb/tb_flash_burst_splitter.sv
// tb_flash_burst_splitter: directed and random Gets checked against an arithmetic burst model
module tb_flash_burst_splitter;
`ifdef FLASH_BURST_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  flash_burst_splitter_if #(.TL_RS(4)) up();
  flash_burst_splitter_if #(.TL_RS(4)) dn();
  flash_burst_splitter #(.TL_RS(4), .MAX_SIZE(6)) dut (
    .fctrl_clock_i(clk), .fctrl_reset_i(rst),
    .burst_a_size(up.a_size), .burst_a_source(up.a_source), .burst_a_address(up.a_address),
    .burst_a_valid(up.a_valid), .burst_a_ready(up.a_ready),
    .burst_d_opcode(up.d_opcode), .burst_d_param(up.d_param), .burst_d_size(up.d_size),
    .burst_d_source(up.d_source), .burst_d_denied(up.d_denied), .burst_d_data(up.d_data),
    .burst_d_corrupt(up.d_corrupt), .burst_d_valid(up.d_valid), .burst_d_ready(up.d_ready),
    .fctrl_a_size(dn.a_size), .fctrl_a_source(dn.a_source), .fctrl_a_address(dn.a_address),
    .fctrl_a_valid(dn.a_valid), .fctrl_a_ready(dn.a_ready),
    .fctrl_d_opcode(dn.d_opcode), .fctrl_d_param(dn.d_param), .fctrl_d_size(dn.d_size),
    .fctrl_d_source(dn.d_source), .fctrl_d_denied(dn.d_denied), .fctrl_d_data(dn.d_data),
    .fctrl_d_corrupt(dn.d_corrupt), .fctrl_d_valid(dn.d_valid), .fctrl_d_ready(dn.d_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_check(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      up.a_valid = 1'b0;
      up.d_ready = 1'b1;
      dn.a_ready = 1'b1;
      dn.d_valid = 1'b1;
      dn.d_data = $urandom;
      #1;
      chk("idle_a_ready", up.a_ready, 1);
      chk("idle_stray_dropped", up.d_valid, 0);
      chk("idle_no_issue", dn.a_valid, 0);
      chk("idle_d_ready", dn.d_ready, 1);
    end
  endtask
  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    up.a_valid = 1'b1;
    up.d_ready = 1'b1;
    dn.a_ready = 1'b1;
    dn.d_valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #1;
      chk("rst_outputs", {up.a_ready, dn.a_valid, up.d_valid, dn.d_ready}, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    up.a_valid = 1'b0;
    #1;
    idle_check(4);
  endtask
  task automatic do_get(input logic [3:0] s, input logic [3:0] src, input logic [23:0] addr,
                        input int hold_d, input int stop_after);
    int n, se, base, a_int, na, b, a_cyc, a_stall, d_wait, u_hold, stop;
    bit mis, d_pend, stalled;
    logic [31:0] d_data;
    logic [23:0] held_addr;
    a_int = int'(addr);
    se = (s > 6) ? 6 : int'(s);
    n = (s < 2) ? 1 : (1 << (se - 2));
    base = (s >= 2) ? ((a_int >> s) << s) : a_int;
    mis = ALIGN_CHK && s >= 2 && (a_int % (1 << s)) != 0;
    stop = (stop_after < 0) ? n : stop_after;
    @(negedge clk);
    dn.d_valid = 1'b0;
    up.a_valid = 1'b1;
    up.a_size = s;
    up.a_source = src;
    up.a_address = addr;
    #1;
    chk("a_accept", up.a_ready, 1);
    @(negedge clk);
    up.a_valid = 1'b0;
    up.a_address = 24'($urandom);
    na = 0; b = 0; a_cyc = 0; d_pend = 1'b0; d_wait = 0; stalled = 1'b0;
    a_stall = $urandom_range(0, 2);
    u_hold = hold_d;
    d_data = '0;
    held_addr = '0;
    for (int c = 0; c < 600 && b < stop; c++) begin
      dn.a_ready = (a_stall == 0);
      dn.d_valid = d_pend && d_wait == 0;
      dn.d_data = d_data;
      dn.d_source = src;
      dn.d_size = 4'd2;
      dn.d_opcode = 3'd1;
      dn.d_param = 2'd0;
      dn.d_denied = 1'b0;
      dn.d_corrupt = 1'b0;
      up.d_ready = (u_hold == 0);
      #1;
      if (!mis) chk("d_valid_pass", up.d_valid, d_pend && dn.d_valid);
      if (up.d_valid && up.d_ready) begin
        chk("d_data", up.d_data, mis ? 32'd0 : d_data);
        chk("d_size", up.d_size, s);
        chk("d_source", up.d_source, src);
        chk("d_flags", {up.d_opcode, up.d_denied, up.d_corrupt}, {3'd1, mis, mis});
        b++;
        u_hold = hold_d;
      end else if (up.d_valid) begin
        if (!mis) chk("d_backpressure", dn.d_ready, 0);
        if (u_hold > 0) u_hold--;
      end
      if (dn.d_valid && dn.d_ready) d_pend = 1'b0;
      else if (d_pend && d_wait > 0) d_wait--;
      if (dn.a_valid) begin
        a_cyc++;
        if (stalled) chk("a_stable", dn.a_address, held_addr);
        stalled = !dn.a_ready;
        held_addr = dn.a_address;
        if (dn.a_ready) begin
          chk("a_addr", dn.a_address, 24'((base + 4 * na) & 32'hFFFFFF));
          chk("a_size", dn.a_size, (s < 2) ? s : 4'd2);
          chk("a_source", dn.a_source, src);
          na++;
          d_pend = 1'b1;
          d_data = $urandom;
          d_wait = $urandom_range(0, 2);
          a_stall = $urandom_range(0, 2);
        end else a_stall--;
      end
      if (b < stop) @(negedge clk);
    end
    chk("beats_done", b, stop);
    if (stop == n) chk("a_count", na, mis ? 0 : n);
    if (mis) chk("deny_no_traffic", a_cyc, 0);
  endtask
  initial begin
    logic [3:0] s;
    logic [23:0] addr;
    up.a_valid = 1'b0; up.a_size = '0; up.a_source = '0; up.a_address = '0; up.d_ready = 1'b0;
    dn.a_ready = 1'b0; dn.d_valid = 1'b0; dn.d_opcode = '0; dn.d_param = '0; dn.d_size = '0;
    dn.d_source = '0; dn.d_denied = 1'b0; dn.d_data = '0; dn.d_corrupt = 1'b0;
    reset_pulse(2);
    do_get(4'd2, 4'd1, 24'h000100, 0, -1);
    do_get(4'd4, 4'd3, 24'h001010, 0, -1);
    do_get(4'd3, 4'd5, 24'hFFFFF8, 5, -1);
    do_get(4'd3, 4'd2, 24'h000004, 0, -1);
    idle_check(3);
    do_get(4'd0, 4'd6, 24'h000123, 1, -1);
    do_get(4'd7, 4'd9, 24'h000400, 0, -1);
    do_get(4'd4, 4'd7, 24'h000400, 0, 2);
    reset_pulse(2);
    do_get(4'd2, 4'd0, 24'h000020, 0, -1);
    for (int i = 0; i < 25; i++) begin
      s = 4'($urandom_range(0, 7));
      addr = 24'($urandom);
      if ($urandom_range(0, 1) == 0) addr = addr & 24'hFFFFC0;
      do_get(s, 4'($urandom), addr, $urandom_range(0, 2), -1);
      if ($urandom_range(0, 3) == 0) idle_check(1);
    end
    idle_check(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
